npc_btb: RTL

NPC_BTB -- requirements
Module: npc_btb

---
 rtl/npc_btb.sv | 105 ++++++++++
 1 files changed

// File: rtl/npc_btb.sv
// Fetch PC register with a direct-mapped branch target buffer that predicts the next PC.
// Each entry holds a valid bit, a tag, a target and a 2-bit saturating counter, trained from execute.
module npc_btb #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            pred_taken
);

  localparam int IDXW = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - 2 - IDXW;

  logic [XLEN-1:0]      pc_q, pc_d;
  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAGW-1:0]      tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]      target_q [BTB_DEPTH];
  logic [1:0]           ctr_q    [BTB_DEPTH];

  logic [IDXW-1:0] lkIdx, updIdx;
  logic [TAGW-1:0] lkTag, updTag;
  logic            lkHit, updHit;
  logic [XLEN-1:0] lkTarget;
  logic [1:0]      updCtr, ctrInc, ctrDec;
  logic            unusedBits;

  assign lkIdx    = pc_q[2+IDXW-1:2];
  assign lkTag    = pc_q[XLEN-1:2+IDXW];
  assign lkHit    = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
  assign lkTarget = target_q[lkIdx];

  assign updIdx = upd_pc[2+IDXW-1:2];
  assign updTag = upd_pc[XLEN-1:2+IDXW];
  assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);
  assign updCtr = ctr_q[updIdx];
  assign ctrInc = (updCtr == 2'b11) ? 2'b11 : updCtr + 2'd1;
  assign ctrDec = (updCtr == 2'b00) ? 2'b00 : updCtr - 2'd1;

  // Target bit 0 is kept in storage but forced low when used as a fetch address.
  assign unusedBits = ^{upd_pc[1:0], redirect_pc[0], lkTarget[0]};

  assign pred_taken = lkHit && ctr_q[lkIdx][1];
  assign pc         = pc_q;

  always_comb begin
    npc = pc_q + XLEN'(4);
    if (pred_taken) begin
      npc = {lkTarget[XLEN-1:1], 1'b0};
    end
  end

  // Redirect beats stall so a mispredict is never lost behind a held fetch.
  always_comb begin
    pc_d = npc;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:1], 1'b0};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        valid_q[updIdx] <= 1'b1;
        ctr_q[updIdx]   <= updHit ? ctrInc : 2'b10;
      end else if (updHit) begin
        ctr_q[updIdx] <= ctrDec;
      end
    end
  end

  // Tag and target need no reset: they are ignored until valid is set.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      tag_q[updIdx]    <= updTag;
      target_q[updIdx] <= upd_target;
    end
  end

endmodule
